polyphase_interp2: RTL and testbench

Rate-doubling polyphase interpolator, the rate-up counterpart of the team's even/odd split IIR datapath.
- Accepts at most one input sample every two clocks through a valid/ready handshake.
- Emits two output samples per input on consecutive clocks: an even phase (delayed input copy) and an odd phase (4-tap shift-add half-band value, taps −1, 9, 9, −1, /16).
- Sits downstream of half-rate processing and produces a full-clock-rate stream.

---
 rtl/dsp_pkg.sv | 17 +
 rtl/polyphase_interp2_kernel.sv | 42 ++++
 rtl/polyphase_interp2.sv | 125 ++++++++++++
 tb/tb_polyphase_interp2.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the rate-change datapaths.
// State encoding and fixed half-band coefficients.
package dsp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EVEN,
      ODD
   } state_t;

   localparam int C_CENTER  = 9;
   localparam int C_OUTER   = 1;
   localparam int C_SHIFT   = 4;
   localparam int C_ROUND   = 8;
   localparam int PRIME_CNT = 4;

endpackage

// File: rtl/polyphase_interp2_kernel.sv
// Half-band odd-phase kernel: taps -1,9,9,-1 over 16,
// rounded half toward +inf and saturated to the sample range.
import dsp_pkg::*;

module interp_kernel #(
   parameter int W = 14
) (
   input  logic signed [W:0] d0,
   input  logic signed [W:0] d1,
   input  logic signed [W:0] d2,
   input  logic signed [W:0] d3,
   output logic signed [W:0] odd
);

   localparam int SW   = W + 8;
   localparam int MAXI = (1 << W) - 1;
   localparam int MINI = -(1 << W);

   localparam logic signed [SW-1:0] MAXV = SW'(MAXI);
   localparam logic signed [SW-1:0] MINV = SW'(MINI);

   logic signed [SW-1:0] inner;
   logic signed [SW-1:0] outer;
   logic signed [SW-1:0] s;
   logic signed [SW-1:0] r;

   // Shift-add filter sum, round, then clamp to W+1 bits.
   always_comb begin
      inner = SW'(d1) + SW'(d2);
      outer = SW'(d0) + SW'(d3);
      // Centre tap of 9 built as 8a + a.
      s     = (inner <<< 3) + inner - outer;
      r     = (s + SW'(C_ROUND)) >>> C_SHIFT;
      odd   = r[W:0];
      if (r > MAXV) begin
         odd = MAXV[W:0];
      end else if (r < MINV) begin
         odd = MINV[W:0];
      end
   end

endmodule

// File: rtl/polyphase_interp2.sv
// Rate-doubling polyphase interpolator: one input every
// two clocks in, an even/odd output pair on consecutive clocks.
import dsp_pkg::*;

module polyphase_interp2 #(
   parameter int W = 14
) (
   input  logic                clk,
   input  logic                reset,
   input  logic signed [W:0]   x_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic signed [W:0]   y_out,
   output logic                y_valid,
   output logic                y_phase
);

   state_t state;
   state_t state_nx;

   logic signed [W:0] d0;
   logic signed [W:0] d1;
   logic signed [W:0] d2;
   logic signed [W:0] d3;
   logic signed [W:0] odd;

   logic [2:0] count;
   logic       accept;
   logic       primed;

   assign accept = in_valid & in_ready;
   assign primed = (count == 3'(PRIME_CNT));

   interp_kernel #(
      .W (W)
   ) u_kernel (
      .d0  (d0),
      .d1  (d1),
      .d2  (d2),
      .d3  (d3),
      .odd (odd)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and ready; ready depends on state only, so in
   // IDLE/ODD an accept is simply in_valid.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = EVEN;
         end
         EVEN: begin
            state_nx = ODD;
         end
         ODD: begin
            in_ready = 1'b1;
            state_nx = in_valid ? EVEN : IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Delay line shifts on every accepted sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d0 <= '0;
         d1 <= '0;
         d2 <= '0;
         d3 <= '0;
      end else if (accept) begin
         d3 <= d2;
         d2 <= d1;
         d1 <= d0;
         d0 <= x_in;
      end
   end

   // Prime counter saturates once the delay line is full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (accept && !primed) begin
         count <= count + 3'd1;
      end
   end

   // Output register: even copy, odd interpolant, or idle gap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_out   <= '0;
         y_valid <= 1'b0;
         y_phase <= 1'b0;
      end else begin
         unique case (state)
            EVEN: begin
               y_out   <= d2;
               y_phase <= 1'b0;
               y_valid <= primed;
            end
            ODD: begin
               y_out   <= odd;
               y_phase <= 1'b1;
               y_valid <= primed;
            end
            default: begin
               y_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_polyphase_interp2.sv
// Directed bench for polyphase_interp2.
// Hand-computed vectors for impulse, DC, saturation, gaps, reset.
module tb_polyphase_interp2;

   logic               clk;
   logic               reset;
   logic signed [14:0] x_in;
   logic               in_valid;
   logic               in_ready;
   logic signed [14:0] y_out;
   logic               y_valid;
   logic               y_phase;

   int checks;
   int errors;

   logic signed [14:0] ov_y;
   logic               ov_v;
   logic               ov_p;
   logic signed [14:0] ev_y;
   logic               ev_v;
   logic               ev_p;
   logic               r_pre;
   logic               r_mid;

   polyphase_interp2 #(
      .W (14)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .x_in     (x_in),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .y_out    (y_out),
      .y_valid  (y_valid),
      .y_phase  (y_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      x_in     = '0;
      reset    = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Accept x, then step through the EVEN cycle.
   // ov_* holds outputs after the accept edge (previous odd),
   // ev_* holds outputs after the following edge (even).
   task automatic push(input int x);
      x_in     = 15'(x);
      in_valid = 1'b1;
      r_pre    = in_ready;
      tick();
      ov_y  = y_out;
      ov_v  = y_valid;
      ov_p  = y_phase;
      r_mid = in_ready;
      tick();
      ev_y = y_out;
      ev_v = y_valid;
      ev_p = y_phase;
   endtask

   task automatic flush();
      in_valid = 1'b0;
      tick();
      ov_y = y_out;
      ov_v = y_valid;
      ov_p = y_phase;
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      x_in     = '0;
      reset    = 1'b1;
      #2;
      checks++;
      if (y_out !== 15'sd0) begin
         errors++;
         $display("FAIL reset_y_out got %0d want 0", y_out);
      end
      checks++;
      if (y_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_y_valid got %b want 0", y_valid);
      end
      checks++;
      if (y_phase !== 1'b0) begin
         errors++;
         $display("FAIL reset_y_phase got %b want 0", y_phase);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_impulse();
      int imp[7]    = '{0, 0, 0, 1024, 0, 0, 0};
      int ev_exp[7] = '{0, 0, 0, 0, 0, 1024, 0};
      int od_exp[7] = '{0, 0, 0, -64, 576, 576, -64};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         push(imp[i]);
         checks++;
         if (r_pre !== 1'b1 || r_mid !== 1'b0) begin
            errors++;
            $display("FAIL imp_ready[%0d] got %b%b want 10",
                     i, r_pre, r_mid);
         end
         if (i > 0) begin
            checks++;
            if (ov_v !== (i - 1 >= 3)) begin
               errors++;
               $display("FAIL imp_odd_valid[%0d] got %b", i - 1, ov_v);
            end
            if (i - 1 >= 3) begin
               checks++;
               if (ov_y !== 15'(od_exp[i-1]) || ov_p !== 1'b1) begin
                  errors++;
                  $display("FAIL imp_odd[%0d] got %0d/%b want %0d/1",
                           i - 1, ov_y, ov_p, od_exp[i-1]);
               end
            end
         end
         checks++;
         if (ev_v !== (i >= 3)) begin
            errors++;
            $display("FAIL imp_even_valid[%0d] got %b", i, ev_v);
         end
         if (i >= 3) begin
            checks++;
            if (ev_y !== 15'(ev_exp[i]) || ev_p !== 1'b0) begin
               errors++;
               $display("FAIL imp_even[%0d] got %0d/%b want %0d/0",
                        i, ev_y, ev_p, ev_exp[i]);
            end
         end
      end
      flush();
      checks++;
      if (ov_v !== 1'b1 || ov_y !== -15'sd64 || ov_p !== 1'b1) begin
         errors++;
         $display("FAIL imp_odd_last got %b/%0d/%b want 1/-64/1",
                  ov_v, ov_y, ov_p);
      end
      tick();
      checks++;
      if (y_valid !== 1'b0 || y_out !== -15'sd64) begin
         errors++;
         $display("FAIL imp_idle got %b/%0d want 0/-64",
                  y_valid, y_out);
      end
   endtask

   task automatic test_dc();
      for (int i = 0; i < 6; i++) begin
         push(1000);
         checks++;
         if (ev_v !== 1'b1) begin
            errors++;
            $display("FAIL dc_even_valid[%0d] got %b want 1", i, ev_v);
         end
         if (i >= 1) begin
            checks++;
            if (ov_v !== 1'b1) begin
               errors++;
               $display("FAIL dc_odd_valid[%0d] got %b want 1", i, ov_v);
            end
         end
         if (i >= 3) begin
            checks++;
            if (ev_y !== 15'sd1000) begin
               errors++;
               $display("FAIL dc_even[%0d] got %0d want 1000", i, ev_y);
            end
         end
         if (i >= 4) begin
            checks++;
            if (ov_y !== 15'sd1000) begin
               errors++;
               $display("FAIL dc_odd[%0d] got %0d want 1000", i, ov_y);
            end
         end
      end
      flush();
      checks++;
      if (ov_v !== 1'b1 || ov_y !== 15'sd1000) begin
         errors++;
         $display("FAIL dc_odd_last got %b/%0d want 1/1000", ov_v, ov_y);
      end
   endtask

   task automatic test_saturation();
      int pos[4] = '{-16384, 16383, 16383, -16384};
      int neg[4] = '{16383, -16384, -16384, 16383};
      do_reset();
      for (int i = 0; i < 4; i++) push(pos[i]);
      checks++;
      if (ev_v !== 1'b1 || ev_y !== 15'sd16383) begin
         errors++;
         $display("FAIL sat_pos_even got %b/%0d want 1/16383", ev_v, ev_y);
      end
      flush();
      checks++;
      if (ov_v !== 1'b1 || ov_y !== 15'sd16383) begin
         errors++;
         $display("FAIL sat_pos_odd got %b/%0d want 1/16383", ov_v, ov_y);
      end
      for (int i = 0; i < 4; i++) push(neg[i]);
      checks++;
      if (ev_y !== -15'sd16384) begin
         errors++;
         $display("FAIL sat_neg_even got %0d want -16384", ev_y);
      end
      flush();
      checks++;
      if (ov_v !== 1'b1 || ov_y !== -15'sd16384) begin
         errors++;
         $display("FAIL sat_neg_odd got %b/%0d want 1/-16384", ov_v, ov_y);
      end
   endtask

   task automatic test_gaps();
      x_in     = 15'sd100;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_ready_a got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL gap_ready_b got %b want 0", in_ready);
      end
      tick();
      checks++;
      if (y_valid !== 1'b1 || y_phase !== 1'b0 || y_out !== -15'sd16384) begin
         errors++;
         $display("FAIL gap_even1 got %b/%b/%0d want 1/0/-16384",
                  y_valid, y_phase, y_out);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_ready_c got %b want 1", in_ready);
      end
      tick();
      checks++;
      if (y_valid !== 1'b1 || y_phase !== 1'b1 || y_out !== 15'sd1017) begin
         errors++;
         $display("FAIL gap_odd1 got %b/%b/%0d want 1/1/1017",
                  y_valid, y_phase, y_out);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL gap_ready_d got %b want 1", in_ready);
      end
      x_in     = 15'sd200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (y_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL gap_idle got %b/%b want 0/0", y_valid, in_ready);
      end
      tick();
      checks++;
      if (y_valid !== 1'b1 || y_phase !== 1'b0 || y_out !== 15'sd16383) begin
         errors++;
         $display("FAIL gap_even2 got %b/%b/%0d want 1/0/16383",
                  y_valid, y_phase, y_out);
      end
      tick();
      checks++;
      if (y_valid !== 1'b1 || y_phase !== 1'b1 || y_out !== 15'sd10283) begin
         errors++;
         $display("FAIL gap_odd2 got %b/%b/%0d want 1/1/10283",
                  y_valid, y_phase, y_out);
      end
      tick();
      checks++;
      if (y_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_tail got %b want 0", y_valid);
      end
   endtask

   task automatic test_reset_mid();
      int pr[4] = '{5, 6, 7, 8};
      x_in     = 15'sd50;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (y_out !== 15'sd0 || y_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset got %0d/%b/%b want 0/0/1",
                  y_out, y_valid, in_ready);
      end
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         push(pr[i]);
         checks++;
         if (ev_v !== (i == 3)) begin
            errors++;
            $display("FAIL reprime_valid[%0d] got %b", i, ev_v);
         end
         if (i > 0) begin
            checks++;
            if (ov_v !== 1'b0) begin
               errors++;
               $display("FAIL reprime_odd_valid[%0d] got %b want 0",
                        i, ov_v);
            end
         end
      end
      checks++;
      if (ev_y !== 15'sd6) begin
         errors++;
         $display("FAIL reprime_even got %0d want 6", ev_y);
      end
      flush();
      checks++;
      if (ov_v !== 1'b1 || ov_y !== 15'sd7) begin
         errors++;
         $display("FAIL reprime_odd got %b/%0d want 1/7", ov_v, ov_y);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      x_in     = '0;
      test_reset();
      test_impulse();
      test_dc();
      test_saturation();
      test_gaps();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
